// File: rtl/line_buffer_scheduler.sv
// rtl/line_buffer_scheduler.sv - write steering, fill tracking and 3-line window read sequencing
// for the four line buffers feeding the 3x3 kernel stage.
module line_buffer_scheduler #(
  parameter int LINE_WIDTH = 512,
  parameter int ADDR_W     = 9,
  parameter int NUM_LINES  = 4
) (
  input  logic              axi_clk,
  input  logic              axi_reset,
  input  logic              i_pixel_valid,
  input  logic              i_out_ready,
  output logic              o_pixel_ready,
  output logic [3:0]        o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [3:0]        o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [1:0]        o_rd_top,
  output logic [11:0]       o_fill,
  output logic              o_intr,
  output logic              o_overflow
);

  localparam logic [11:0]       FULL_LVL  = 12'(NUM_LINES * LINE_WIDTH);
  localparam logic [11:0]       READ_LVL  = 12'(3 * LINE_WIDTH);
  localparam logic [11:0]       LINE_LVL  = 12'(LINE_WIDTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_WIDTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic {S_IDLE, S_READ} state_t;

  state_t            state_q, state_d;
  logic [1:0]        wr_sel_q, wr_sel_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]        rd_top_q, rd_top_d;
  logic [11:0]       fill_q, fill_d;
  logic              intr_q, intr_d;
  logic              overflow_q, overflow_d;

  logic       accept;
  logic       rd_fire;
  logic       retire;
  logic [1:0] excluded_line;
  logic [3:0] window_mask;

  // Writes are gated during reset so a held valid never touches the buffers.
  assign o_pixel_ready = (fill_q < FULL_LVL);
  assign accept        = i_pixel_valid & o_pixel_ready & ~axi_reset;
  assign o_wr_en       = (4'b0001 << wr_sel_q) & {4{accept}};
  assign o_wr_addr     = wr_addr_q;

  // The window is every buffer except the one just behind rd_top (the one being refilled).
  assign excluded_line = rd_top_q - 2'd1;
  assign window_mask   = ~(4'b0001 << excluded_line);

  assign retire     = rd_fire && (rd_addr_q == LAST_ADDR);
  assign o_rd_addr  = rd_addr_q;
  assign o_rd_top   = rd_top_q;
  assign o_fill     = fill_q;
  assign o_intr     = intr_q;
  assign o_overflow = overflow_q;

  // FSM state register
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fill_q >= READ_LVL) state_d = S_READ;
      S_READ:  if (retire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    rd_fire = 1'b0;
    o_rd_en = 4'b0000;
    if (state_q == S_READ) begin
      rd_fire = i_out_ready & ~axi_reset;
      o_rd_en = window_mask & {4{rd_fire}};
    end
  end

  // Datapath next state
  always_comb begin
    wr_sel_d   = wr_sel_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    rd_top_d   = rd_top_q;
    overflow_d = overflow_q | (i_pixel_valid & ~o_pixel_ready);
    intr_d     = retire;
    fill_d     = fill_q + {11'd0, accept} - (retire ? LINE_LVL : 12'd0);

    if (accept) begin
      if (wr_addr_q == LAST_ADDR) begin
        wr_addr_d = '0;
        wr_sel_d  = wr_sel_q + 2'd1;
      end else begin
        wr_addr_d = wr_addr_q + ADDR_ONE;
      end
    end

    if (rd_fire) begin
      if (retire) begin
        rd_addr_d = '0;
        rd_top_d  = rd_top_q + 2'd1;
      end else begin
        rd_addr_d = rd_addr_q + ADDR_ONE;
      end
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      wr_sel_q   <= 2'd0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      rd_top_q   <= 2'd0;
      fill_q     <= 12'd0;
      intr_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_sel_q   <= wr_sel_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      rd_top_q   <= rd_top_d;
      fill_q     <= fill_d;
      intr_q     <= intr_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
